key_debounce_scan: RTL and testbench

- Input conditioning stage that sits directly upstream of the 7-segment display block.
- Synchronises and debounces the 9 launchpad keys and the mode switch.
- Produces clean levels, one-cycle press pulses, an encoded key code with strobe, and a debounced mode level with change pulse.
- Output KEY_LEVEL drives the display block's KEY[8:0] input; MODE_LEVEL drives its Mode_Switch input.

---
 rtl/key_debounce_scan_pkg.sv | 20 ++
 rtl/key_debounce_scan_debounce_cell.sv | 49 ++++
 rtl/key_debounce_scan.sv | 100 ++++++++++
 tb/tb_key_debounce_scan.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_scan_pkg.sv
// rtl/key_debounce_scan_pkg.sv - shared sizes, default timing and repeat constants for key_debounce_scan
package key_debounce_scan_pkg;

  localparam int KEY_NUM            = 9;
  localparam int KEY_CODE_W         = 4;
  localparam int TICK_CYCLES_DEF    = 24000;
  localparam int DEBOUNCE_TICKS_DEF = 10;
  localparam int REPEAT_DELAY_TICKS = 500;
  localparam int REPEAT_RATE_TICKS  = 100;
  localparam int REPEAT_CNT_W       = 9;

  // Priority encoder: lowest set bit wins when several keys are accepted together.
  function automatic logic [KEY_CODE_W-1:0] lowest_index(input logic [KEY_NUM-1:0] v);
    lowest_index = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = KEY_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_debounce_scan_debounce_cell.sv
// rtl/key_debounce_scan_debounce_cell.sv - 2-flop synchroniser plus tick-based stable/counter debounce for one input
module debounce_cell #(
  parameter int DEBOUNCE_TICKS = 10,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          norm;
  logic [CW-1:0] cnt;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q1 <= ACTIVE_LOW;
      sync_q2 <= ACTIVE_LOW;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign norm   = sync_q2 ^ ACTIVE_LOW;
  assign accept = tick && (norm != level) && (cnt == CW'(DEBOUNCE_TICKS - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (norm == level) begin
      cnt <= '0;
    end else if (accept) begin
      level <= ~level;
      cnt   <= '0;
    end else if (tick && (cnt != CW'(DEBOUNCE_TICKS))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_debounce_scan.sv
// rtl/key_debounce_scan.sv - debounces 9 keys and the mode switch, emits press pulses and key code
// Optional auto-repeat of held keys is enabled by defining KEY_REPEAT_EN.
module key_debounce_scan
  import key_debounce_scan_pkg::*;
#(
  parameter int N_KEYS         = KEY_NUM,
  parameter int TICK_CYCLES    = TICK_CYCLES_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_KEYS-1:0]     KEY_RAW,
  input  logic                  MODE_RAW,
  output logic [N_KEYS-1:0]     KEY_LEVEL,
  output logic [N_KEYS-1:0]     KEY_PRESS,
  output logic [KEY_CODE_W-1:0] KEY_CODE,
  output logic                  KEY_STB,
  output logic                  MODE_LEVEL,
  output logic                  MODE_CHG
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [N_KEYS-1:0] key_accept;
  logic [N_KEYS-1:0] repeat_fire;
  logic [N_KEYS-1:0] press_next;
  logic              mode_accept;

  assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .ACTIVE_LOW    (KEY_ACTIVE_LOW != 0)
    ) u_cell (
      .CLK   (CLK),
      .RESET (RESET),
      .raw   (KEY_RAW[g]),
      .tick  (tick),
      .level (KEY_LEVEL[g]),
      .accept(key_accept[g])
    );

`ifdef KEY_REPEAT_EN
    // Counts ticks while held; after the first repeat it is rewound so later repeats are REPEAT_RATE apart.
    logic [REPEAT_CNT_W-1:0] rep_cnt;

    assign repeat_fire[g] = KEY_LEVEL[g] && tick &&
                            (rep_cnt == REPEAT_CNT_W'(REPEAT_DELAY_TICKS - 1));

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)             rep_cnt <= '0;
      else if (!KEY_LEVEL[g]) rep_cnt <= '0;
      else if (tick)          rep_cnt <= repeat_fire[g] ?
                                         REPEAT_CNT_W'(REPEAT_DELAY_TICKS - REPEAT_RATE_TICKS) :
                                         rep_cnt + 1'b1;
    end
`else
    assign repeat_fire[g] = 1'b0;
`endif
  end

  debounce_cell #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .ACTIVE_LOW    (1'b0)
  ) u_mode_cell (
    .CLK   (CLK),
    .RESET (RESET),
    .raw   (MODE_RAW),
    .tick  (tick),
    .level (MODE_LEVEL),
    .accept(mode_accept)
  );

  // Only 0->1 acceptances count as presses; releases are silent.
  assign press_next = (key_accept & ~KEY_LEVEL) | repeat_fire;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      KEY_PRESS <= '0;
      KEY_STB   <= 1'b0;
      KEY_CODE  <= '0;
      MODE_CHG  <= 1'b0;
    end else begin
      KEY_PRESS <= press_next;
      KEY_STB   <= |press_next;
      if (|press_next) KEY_CODE <= lowest_index(press_next);
      MODE_CHG  <= mode_accept;
    end
  end

endmodule

// File: tb/tb_key_debounce_scan.sv
// tb/tb_key_debounce_scan.sv - randomized self-checking bench for key_debounce_scan against a tick-arithmetic model
module tb_key_debounce_scan;

  localparam int T          = 4;
  localparam int DT         = 3;
  localparam int NK         = 9;
  localparam int REP_DELAY  = 500;
  localparam int REP_RATE   = 100;
`ifdef KEY_REPEAT_EN
  localparam int EXP_HOLD_PRESSES = 3;
`else
  localparam int EXP_HOLD_PRESSES = 1;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [NK-1:0] KEY_RAW = '1;
  logic          MODE_RAW = 1'b0;
  logic [NK-1:0] KEY_LEVEL;
  logic [NK-1:0] KEY_PRESS;
  logic [3:0]    KEY_CODE;
  logic          KEY_STB;
  logic          MODE_LEVEL;
  logic          MODE_CHG;

  key_debounce_scan #(
    .N_KEYS(NK), .TICK_CYCLES(T), .DEBOUNCE_TICKS(DT), .KEY_ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .KEY_RAW(KEY_RAW), .MODE_RAW(MODE_RAW),
    .KEY_LEVEL(KEY_LEVEL), .KEY_PRESS(KEY_PRESS), .KEY_CODE(KEY_CODE),
    .KEY_STB(KEY_STB), .MODE_LEVEL(MODE_LEVEL), .MODE_CHG(MODE_CHG)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model state: index 9 is the mode switch, 0..8 are keys.
  int          e;
  int          last_agree [10];
  int          press_edge [NK];
  logic [9:0]  s_vec;
  logic [9:0]  r1;
  logic [9:0]  r2;
  logic [NK-1:0] exp_press;
  logic [3:0]  exp_code;
  logic        exp_stb;
  logic        exp_chg;

  int press_total [NK] = '{default: 0};
  int stb_total = 0;
  int chg_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Number of tick edges with index in 0..x (ticks land where index mod T == T-1).
  function automatic int ticks_upto(input int x);
    return (x + 1) / T;
  endfunction

  function automatic logic [3:0] first_set(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic step();
    logic [9:0]    rawv;
    logic [NK-1:0] ep;
    logic          chg;
    logic          norm;
    logic          sb;
    int            n;
    @(posedge CLK);
    if (!RESET) begin
      for (int i = 0; i < 10; i++) last_agree[i] = -1;
      s_vec = '0;
      r1 = {1'b0, {NK{1'b1}}};
      r2 = {1'b0, {NK{1'b1}}};
      e = 0;
      exp_press = '0; exp_stb = 1'b0; exp_code = '0; exp_chg = 1'b0;
    end else begin
      rawv = {MODE_RAW, KEY_RAW};
      ep = '0;
      chg = 1'b0;
      for (int i = 0; i < 10; i++) begin
        norm = (i < NK) ? ~r2[i] : r2[i];
        sb = s_vec[i];
        if (norm == s_vec[i]) begin
          last_agree[i] = e;
        end else if (ticks_upto(e) - ticks_upto(last_agree[i]) >= DT) begin
          s_vec[i] = ~s_vec[i];
          last_agree[i] = e;
          if (i == NK) chg = 1'b1;
          else if (!sb) begin ep[i] = 1'b1; press_edge[i] = e; end
        end
`ifdef KEY_REPEAT_EN
        if (i < NK && sb && (e % T == T - 1)) begin
          n = ticks_upto(e) - ticks_upto(press_edge[i]);
          if (n >= REP_DELAY && (n - REP_DELAY) % REP_RATE == 0) ep[i] = 1'b1;
        end
`else
        n = 0;
`endif
        r2[i] = r1[i];
        r1[i] = rawv[i];
      end
      exp_press = ep;
      exp_stb   = |ep;
      if (|ep) exp_code = first_set(ep);
      exp_chg   = chg;
      e++;
    end
    #1;
    check("key_level",  32'(KEY_LEVEL),  32'(s_vec[NK-1:0]));
    check("key_press",  32'(KEY_PRESS),  32'(exp_press));
    check("key_stb",    32'(KEY_STB),    32'(exp_stb));
    check("key_code",   32'(KEY_CODE),   32'(exp_code));
    check("mode_level", 32'(MODE_LEVEL), 32'(s_vec[9]));
    check("mode_chg",   32'(MODE_CHG),   32'(exp_chg));
    for (int i = 0; i < NK; i++) if (KEY_PRESS[i]) press_total[i]++;
    if (KEY_STB) stb_total++;
    if (MODE_CHG) chg_total++;
    @(negedge CLK);
  endtask

  function automatic int press_sum();
    int t = 0;
    for (int i = 0; i < NK; i++) t += press_total[i];
    return t;
  endfunction

  initial begin
    int snap;
    int n;
    bit got;

    // Reset with toggling pins, then idle.
    RESET = 1'b0;
    for (int c = 0; c < 10; c++) begin KEY_RAW = 9'($urandom); step(); end
    check("reset_outputs", 32'({KEY_LEVEL, KEY_PRESS, KEY_CODE, KEY_STB, MODE_LEVEL, MODE_CHG}), 32'd0);
    KEY_RAW = '1;
    RESET = 1'b1;
    snap = press_sum();
    repeat (100) step();
    check("idle_level", 32'(KEY_LEVEL), 32'd0);
    check("idle_presses", 32'(press_sum() - snap), 32'd0);

    // Clean press of key 4.
    KEY_RAW[4] = 1'b0;
    n = 0; got = 0;
    while (!got && n < 40) begin step(); n++; if (KEY_LEVEL[4]) got = 1; end
    check("press4_found", 32'(got), 32'd1);
    check_range("press4_latency", n, 10, 14);
    check("press4_vec",  32'(KEY_PRESS), 32'h010);
    check("press4_code", 32'(KEY_CODE),  32'd4);
    check("press4_stb",  32'(KEY_STB),   32'd1);
    step();
    check("press4_single", 32'(KEY_PRESS), 32'd0);
    KEY_RAW[4] = 1'b1;
    repeat (20) step();
    check("release4_level", 32'(KEY_LEVEL[4]), 32'd0);
    check("press4_total", 32'(press_total[4]), 32'd1);

    // Bounce on key 2 shorter than a tick period is never accepted.
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) KEY_RAW[2] = ~KEY_RAW[2];
      step();
    end
    KEY_RAW[2] = 1'b1;
    repeat (20) step();
    check("bounce2_presses", 32'(press_total[2]), 32'd0);
    check("bounce2_level", 32'(KEY_LEVEL[2]), 32'd0);

    // Simultaneous keys 7 and 1.
    snap = stb_total;
    KEY_RAW[7] = 1'b0; KEY_RAW[1] = 1'b0;
    n = 0; got = 0;
    while (!got && n < 40) begin step(); n++; if (|KEY_PRESS) got = 1; end
    check("simul_found", 32'(got), 32'd1);
    check("simul_vec",  32'(KEY_PRESS), 32'h082);
    check("simul_code", 32'(KEY_CODE),  32'd1);
    repeat (10) step();
    check("simul_stb_count", 32'(stb_total - snap), 32'd1);
    check("simul_code_hold", 32'(KEY_CODE), 32'd1);
    KEY_RAW[7] = 1'b1; KEY_RAW[1] = 1'b1;
    repeat (20) step();

    // Mode switch both edges.
    snap = chg_total;
    MODE_RAW = 1'b1;
    repeat (20) step();
    check("mode_high", 32'(MODE_LEVEL), 32'd1);
    MODE_RAW = 1'b0;
    repeat (20) step();
    check("mode_low", 32'(MODE_LEVEL), 32'd0);
    check("mode_chg_count", 32'(chg_total - snap), 32'd2);

    // Reset in the middle of a debounce.
    snap = press_total[0];
    KEY_RAW[0] = 1'b0;
    repeat (8) step();
    check("midreset_no_early", 32'(press_total[0] - snap), 32'd0);
    RESET = 1'b0;
    repeat (2) step();
    check("midreset_level", 32'(KEY_LEVEL[0]), 32'd0);
    RESET = 1'b1;
    n = 0; got = 0;
    while (!got && n < 40) begin step(); n++; if (KEY_PRESS[0]) got = 1; end
    check("midreset_found", 32'(got), 32'd1);
    check_range("midreset_latency", n, 10, 14);
    repeat (20) step();
    check("midreset_one_press", 32'(press_total[0] - snap), 32'd1);
    KEY_RAW[0] = 1'b1;
    repeat (20) step();

    // Long hold: auto-repeat only when the feature is built in.
    snap = press_total[0];
    KEY_RAW[0] = 1'b0;
    repeat (2500) step();
    KEY_RAW[0] = 1'b1;
    repeat (30) step();
    check("hold_presses", 32'(press_total[0] - snap), 32'(EXP_HOLD_PRESSES));

    // Randomized pin activity with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NK; i++) if ($urandom_range(0, 39) == 0) KEY_RAW[i] = ~KEY_RAW[i];
      if ($urandom_range(0, 59) == 0) MODE_RAW = ~MODE_RAW;
      RESET = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
      step();
    end
    RESET = 1'b1;
    KEY_RAW = '1;
    MODE_RAW = 1'b0;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
